// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl
//    Turns a free-running N-bit loadable up-counter into a start/stop/pause interval
//    timer. It drives the counter's Load/In/En pins and watches its Cout/Out pins.
//    It can reload the preset at terminal count and keeps a saturating tally of the
//    reloads. The design uses one clock domain. Outputs come from registers or from
//    the registered state.
//
// Parameters
//    N        counter width, must match the downstream counter
//    WW       width of the reload tally
//
// Ports
//    clk       in   system clock, rising edge
//    rst       in   asynchronous active-low reset
//    start     in   begin a run with preset (accepted only in IDLE)
//    stop      in   abort the run, return to IDLE
//    pause     in   level; freezes the counter while in RUN
//    auto_rl   in   reload preset at terminal count and keep running
//    preset    in   start value, captured when start is accepted
//    cnt_cout  in   counter carry-out (all ones and En)
//    cnt_q     in   counter value (status mirror only)
//    ld        out  counter Load
//    ld_val    out  counter In (captured preset)
//    cnt_en    out  counter En
//    busy      out  high in LOAD/RUN/HOLD
//    done      out  one-cycle pulse after a terminal count
//    wraps     out  auto-reloads since start, saturating
//    cur_q     out  registered copy of cnt_q
module count_seq_ctrl #(
   parameter int unsigned N  = 10,
   parameter int unsigned WW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          stop,
   input  logic          pause,
   input  logic          auto_rl,
   input  logic [N-1:0]  preset,
   input  logic          cnt_cout,
   input  logic [N-1:0]  cnt_q,
   output logic          ld,
   output logic [N-1:0]  ld_val,
   output logic          cnt_en,
   output logic          busy,
   output logic          done,
   output logic [WW-1:0] wraps,
   output logic [N-1:0]  cur_q
);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StLoad = 2'd1,
      StRun  = 2'd2,
      StHold = 2'd3
   } state_e;

   state_e        state_q, state_d;
   logic [N-1:0]  shadow_q, shadow_d;
   logic [WW-1:0] wraps_q, wraps_d;
   logic          done_q, done_d;
   logic [N-1:0]  mirror_q;

   // Next-state logic. In RUN, stop beats terminal count, and terminal count beats pause.
   // So a pause that arrives with Cout never strands the timer in HOLD.
   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      wraps_d  = wraps_q;
      done_d   = 1'b0;

      case (state_q)
         StIdle: begin
            // If start and stop arrive together, start wins. stop only matters once busy.
            if (start) begin
               shadow_d = preset;
               wraps_d  = '0;
               state_d  = StLoad;
            end
         end

         StLoad: begin
            state_d = stop ? StIdle : StRun;
         end

         StRun: begin
            if (stop) begin
               state_d = StIdle;
            end else if (cnt_cout) begin
               done_d = 1'b1;
               if (auto_rl) begin
                  state_d = StLoad;
                  if (wraps_q != {WW{1'b1}}) begin
                     wraps_d = wraps_q + 1'b1;
                  end
               end else begin
                  state_d = StIdle;
               end
            end else if (pause) begin
               state_d = StHold;
            end
         end

         StHold: begin
            // The counter is disabled here, so it cannot raise Cout.
            if (stop) begin
               state_d = StIdle;
            end else if (!pause) begin
               state_d = StRun;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StIdle;
         shadow_q <= '0;
         wraps_q  <= '0;
         done_q   <= 1'b0;
         mirror_q <= '0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         wraps_q  <= wraps_d;
         done_q   <= done_d;
         mirror_q <= cnt_q;
      end
   end

   // Decoding from the state register makes cnt_en drop together with the async reset.
   assign ld     = (state_q == StLoad);
   assign cnt_en = (state_q == StRun);
   assign busy   = (state_q != StIdle);
   assign ld_val = shadow_q;
   assign done   = done_q;
   assign wraps  = wraps_q;
   assign cur_q  = mirror_q;

endmodule

// File: tb/tb_count_seq_ctrl.sv
module tb_count_seq_ctrl;

   localparam int N  = 10;
   localparam int WW = 8;
   localparam int TOP = (1 << N) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic          pause = 1'b0;
   logic          auto_rl = 1'b0;
   logic [N-1:0]  preset = '0;
   logic          cnt_cout;
   logic [N-1:0]  cnt_q = '0;
   logic          ld;
   logic [N-1:0]  ld_val;
   logic          cnt_en;
   logic          busy;
   logic          done;
   logic [WW-1:0] wraps;
   logic [N-1:0]  cur_q;

   int n_checks = 0;
   int n_bad = 0;
   int cyc = 0;

   typedef struct {
      int cyc;
      int val;
   } ld_ev_t;

   ld_ev_t exp_ld[$];
   int     exp_done[$];

   count_seq_ctrl #(.N(N), .WW(WW)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .stop     (stop),
      .pause    (pause),
      .auto_rl  (auto_rl),
      .preset   (preset),
      .cnt_cout (cnt_cout),
      .cnt_q    (cnt_q),
      .ld       (ld),
      .ld_val   (ld_val),
      .cnt_en   (cnt_en),
      .busy     (busy),
      .done     (done),
      .wraps    (wraps),
      .cur_q    (cur_q)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Downstream loadable up-counter (no reset of its own).
   always @(posedge clk) begin
      if (ld) cnt_q <= ld_val;
      else if (cnt_en) cnt_q <= cnt_q + 1'b1;
   end
   assign cnt_cout = cnt_en & (&cnt_q);

   task automatic check_val(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: each ld and done pulse must match the next queued expectation.
   always @(negedge clk) begin
      if (rst) begin
         if (ld) begin
            if (exp_ld.size() == 0) begin
               check_val("ld_unexpected", 1, 0);
            end else begin
               ld_ev_t e;
               e = exp_ld.pop_front();
               check_val("ld_cycle", cyc, e.cyc);
               check_val("ld_val", int'(ld_val), e.val);
            end
         end
         if (done) begin
            if (exp_done.size() == 0) check_val("done_unexpected", 1, 0);
            else check_val("done_cycle", cyc, exp_done.pop_front());
         end
      end
   end

   task automatic check_drained(input string tag);
      check_val({tag, "_ld_pending"}, exp_ld.size(), 0);
      check_val({tag, "_done_pending"}, exp_done.size(), 0);
   endtask

   // Runs one sequence from IDLE. A reload happens every (TOP-p)+2 cycles. The first done
   // comes (TOP-p)+3 cycles after the start edge. Auto runs stop in the RUN cycle after
   // the last expected reload.
   task automatic run_seq(input string tag, input int p, input bit ar, input int nterm,
                          input bit noise, input bit with_stop);
      int s, per, d0, last;
      preset  = p[N-1:0];
      auto_rl = ar;
      start   = 1'b1;
      stop    = with_stop;
      s       = cyc;
      exp_ld.push_back('{s + 1, p});
      per = (TOP - p) + 2;
      d0  = s + 3 + (TOP - p);
      for (int i = 0; i < nterm; i++) begin
         exp_done.push_back(d0 + i * per);
         if (ar) exp_ld.push_back('{d0 + i * per, p});
      end
      last = d0 + (nterm - 1) * per;
      step();
      start = 1'b0;
      stop  = 1'b0;
      if (ar) begin
         while (cyc < last + 1) begin
            if (noise) begin
               start  = 1'($urandom_range(0, 1));
               preset = N'($urandom_range(0, TOP));
            end
            step();
         end
         start = 1'b0;
         stop  = 1'b1;
         step();
         stop = 1'b0;
         check_val({tag, "_busy_after_stop"}, busy, 0);
      end else begin
         while (cyc < last) begin
            if (noise) begin
               start  = 1'($urandom_range(0, 1));
               preset = N'($urandom_range(0, TOP));
            end
            step();
         end
         start = 1'b0;
         step();
         check_val({tag, "_busy_after_done"}, busy, 0);
      end
      check_val({tag, "_shadow"}, int'(ld_val), p);
      check_drained(tag);
   endtask

   initial begin
      int s;

      // 1a: reset held with random inputs
      for (int i = 0; i < 6; i++) begin
         start   = 1'($urandom_range(0, 1));
         stop    = 1'($urandom_range(0, 1));
         pause   = 1'($urandom_range(0, 1));
         auto_rl = 1'($urandom_range(0, 1));
         preset  = N'($urandom_range(0, TOP));
         step();
         check_val("rst_ld", ld, 0);
         check_val("rst_ld_val", int'(ld_val), 0);
         check_val("rst_cnt_en", cnt_en, 0);
         check_val("rst_busy", busy, 0);
         check_val("rst_done", done, 0);
         check_val("rst_wraps", int'(wraps), 0);
         check_val("rst_cur_q", int'(cur_q), 0);
      end
      start = 0; stop = 0; pause = 0; auto_rl = 0; preset = '0;
      rst = 1'b1;
      step();

      // 1b: reset asserted mid-RUN
      preset  = 10'd1000;
      auto_rl = 1'b1;
      start   = 1'b1;
      exp_ld.push_back('{cyc + 1, 1000});
      step();
      start = 1'b0;
      step();
      step();
      check_val("midrst_running", cnt_en, 1);
      rst = 1'b0;
      #1;
      check_val("midrst_cnt_en", cnt_en, 0);
      check_val("midrst_busy", busy, 0);
      check_val("midrst_ld_val", int'(ld_val), 0);
      #2;
      rst = 1'b1;
      step();
      check_val("midrst_idle_busy", busy, 0);
      check_val("midrst_idle_en", cnt_en, 0);
      step();
      check_val("midrst_still_idle", busy, 0);
      check_drained("midrst");

      // 2: one-shot from 1020
      preset  = 10'd1020;
      auto_rl = 1'b0;
      start   = 1'b1;
      s       = cyc;
      exp_ld.push_back('{s + 1, 1020});
      exp_done.push_back(s + 6);
      step();
      start = 1'b0;
      check_val("os_ld", ld, 1);
      check_val("os_busy_load", busy, 1);
      for (int i = 0; i < 4; i++) begin
         step();
         check_val("os_en", cnt_en, 1);
         check_val("os_cnt_q", int'(cnt_q), 1020 + i);
         if (i > 0) check_val("os_cur_q", int'(cur_q), 1019 + i);
      end
      step();
      check_val("os_done", done, 1);
      check_val("os_en_off", cnt_en, 0);
      check_val("os_busy_off", busy, 0);
      check_val("os_cur_q_top", int'(cur_q), TOP);
      step();
      check_val("os_done_once", done, 0);
      check_val("os_cur_q_wrap", int'(cur_q), 0);
      check_drained("os");

      // 3: auto-reload and saturation
      run_seq("ar5", 1021, 1'b1, 5, 1'b0, 1'b0);
      check_val("ar5_wraps", int'(wraps), 5);
      run_seq("ar300", TOP, 1'b1, 300, 1'b0, 1'b0);
      check_val("ar300_wraps", int'(wraps), 255);

      // 4: pause for 7 cycles after 3 RUN cycles, with start pulses in HOLD
      preset  = 10'd1000;
      auto_rl = 1'b0;
      start   = 1'b1;
      s       = cyc;
      exp_ld.push_back('{s + 1, 1000});
      exp_done.push_back(s + 3 + (TOP - 1000) + 7);
      step();
      start = 1'b0;
      step();
      step();
      step();
      pause = 1'b1;
      for (int i = 0; i < 7; i++) begin
         step();
         check_val("hold_en", cnt_en, 0);
         check_val("hold_cnt_q", int'(cnt_q), 1003);
         check_val("hold_busy", busy, 1);
         start  = (i < 6);
         preset = 10'd7;
         if (i == 6) pause = 1'b0;
      end
      step();
      check_val("resume_en", cnt_en, 1);
      check_val("resume_cnt_q", int'(cnt_q), 1003);
      while (cyc < s + 3 + (TOP - 1000) + 8) step();
      check_val("pause_busy_end", busy, 0);
      check_val("pause_shadow", int'(ld_val), 1000);
      check_drained("pause");

      // 5a: stop with Cout in the same RUN cycle -> no done
      preset  = N'(TOP);
      auto_rl = 1'b0;
      start   = 1'b1;
      exp_ld.push_back('{cyc + 1, TOP});
      step();
      start = 1'b0;
      step();
      check_val("sc_cout", cnt_cout, 1);
      stop = 1'b1;
      step();
      stop = 1'b0;
      check_val("sc_busy", busy, 0);
      check_val("sc_done", done, 0);
      step();
      check_val("sc_done_later", done, 0);
      check_drained("sc");

      // 5b: pause together with Cout -> done and reload/IDLE, never HOLD
      pause = 1'b1;
      run_seq("pc_os", TOP, 1'b0, 1, 1'b0, 1'b0);
      run_seq("pc_ar", TOP, 1'b1, 3, 1'b0, 1'b0);
      check_val("pc_ar_wraps", int'(wraps), 3);
      pause = 1'b0;

      // 6: start/preset noise during the run, then start+stop together in IDLE
      run_seq("noise", 1000, 1'b1, 3, 1'b1, 1'b0);
      check_val("noise_wraps", int'(wraps), 3);
      run_seq("ststop", 1022, 1'b0, 1, 1'b0, 1'b1);
      check_val("ststop_wraps", int'(wraps), 0);

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
